// File: rtl/truth_table_scanner.sv
// Truth-table self-test engine: sweeps all 2^N_IN input vectors, samples the DUT on the last
// dwell cycle of each and compares against EXPECT. Define SCAN_LOOP_EN for continuous sweeping.
module truth_table_scanner #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECT = 8'b1110_1000,
  parameter int DWELL = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [N_IN-1:0]             dut_in,
  input  logic [N_OUT-1:0]            dut_out,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [N_IN:0]               fail_cnt,
  output logic [N_IN-1:0]             fail_idx,
  output logic [(2**N_IN)*N_OUT-1:0]  result
);

  // state   | meaning
  // S_IDLE  | waiting for first start after reset
  // S_APPLY | driving vector idx, counting dwell cycles
  // S_DONE  | sweep finished, results held
  localparam int NV  = 2**N_IN;
  localparam int TW  = NV*N_OUT;
  localparam int TMW = $clog2(DWELL);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;
  state_t state, state_nxt;

  logic [N_IN-1:0] idx;
  logic [TMW-1:0]  timer;
  logic [N_IN:0]   w_cnt;
  logic [N_IN-1:0] w_idx;
  logic [TW-1:0]   w_res;
  logic            start_ok, last_dwell, last_vec, sample, mism;

  assign start_ok   = start && !busy;
  assign last_dwell = timer == TMW'(DWELL-1);
  assign last_vec   = idx == N_IN'(NV-1);
  assign sample     = (state == S_APPLY) && last_dwell;
  assign mism       = dut_out != EXPECT[int'(idx)*N_OUT +: N_OUT];
  assign dut_in     = idx;

`ifdef SCAN_LOOP_EN
  logic stop_req, sweep_end;
`else
  assign fail_cnt = w_cnt;
  assign fail_idx = w_idx;
  assign result   = w_res;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = S_APPLY;
      S_APPLY: begin
        if (sample && last_vec) begin
`ifdef SCAN_LOOP_EN
          if (stop_req) state_nxt = S_DONE;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      timer <= '0;
      w_cnt <= '0;
      w_idx <= '0;
      w_res <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
`ifdef SCAN_LOOP_EN
      stop_req  <= 1'b0;
      sweep_end <= 1'b0;
      fail_cnt  <= '0;
      fail_idx  <= '0;
      result    <= '0;
`endif
    end else if (start_ok) begin
      idx   <= '0;
      timer <= '0;
      w_cnt <= '0;
      w_idx <= '0;
      w_res <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      pass  <= 1'b0;
`ifdef SCAN_LOOP_EN
      stop_req  <= 1'b0;
      sweep_end <= 1'b0;
      fail_cnt  <= '0;
      fail_idx  <= '0;
      result    <= '0;
`endif
    end else begin
      if (state == S_APPLY) begin
        if (last_dwell) begin
          w_res[int'(idx)*N_OUT +: N_OUT] <= dut_out;
          if (mism) begin
            w_cnt <= w_cnt + 1'b1;
            if (w_cnt == '0) w_idx <= idx;
          end
          timer <= '0;
          if (!last_vec) idx <= idx + 1'b1;
`ifdef SCAN_LOOP_EN
          else if (!stop_req) idx <= '0;
`endif
        end else begin
          timer <= timer + 1'b1;
        end
      end
`ifdef SCAN_LOOP_EN
      if (state == S_APPLY && start) stop_req <= 1'b1;
      sweep_end <= sample && last_vec && !stop_req;
      done      <= 1'b0;
      // Publish the finished sweep, then clear the working copy for the next pass.
      if (sweep_end) begin
        done     <= 1'b1;
        pass     <= (w_cnt == '0);
        fail_cnt <= w_cnt;
        fail_idx <= w_idx;
        result   <= w_res;
        w_cnt    <= '0;
        w_idx    <= '0;
        w_res    <= '0;
      end
      if (state == S_DONE) begin
        done     <= 1'b1;
        busy     <= 1'b0;
        pass     <= (w_cnt == '0);
        fail_cnt <= w_cnt;
        fail_idx <= w_idx;
        result   <= w_res;
      end
`else
      if (state == S_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (w_cnt == '0);
      end
`endif
    end
  end

endmodule
